stack_unit: RTL and testbench
=============================

STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of stack entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port push  input  1  write d_in onto stack this cycle.
REQ-006 SHALL have port pop  input  1  remove top entry; the removed value goes to d_out.
REQ-007 SHALL have port top  input  1  copy top entry to d_out without removing it.
REQ-008 SHALL have port d_in  input  WIDTH  data to push.
REQ-009 SHALL have port clr_err  input  1  synchronous clear of the sticky error flags.
REQ-010 SHALL have port d_out  output  WIDTH  registered read data.
REQ-011 SHALL have port count  output  log2(DEPTH)+1  number of valid entries.
REQ-012 SHALL have port empty  output  1  high when count==0; combinational from count.
REQ-013 SHALL have port full  output  1  high when count==DEPTH; combinational from count.
REQ-014 SHALL have port overflow  output  1  sticky: a push was dropped.
REQ-015 SHALL have port underflow  output  1  sticky: a pop or top was made on an empty stack.

Function
REQ-016 SHALL store entries in an internal DEPTH x WIDTH register array, indexed by the stack pointer sp = count.
- The top entry is mem[sp-1].
REQ-017 SHALL operate with one-cycle latency.
- d_out, count and the flags reflect an operation after the edge on which it is sampled.
- A push-then-top sequence on consecutive cycles returns the pushed value.
REQ-018 SHALL, on push only with !full: write mem[sp] <= d_in and set sp <= sp+1.
REQ-019 SHALL, on push only with full: leave mem and sp unchanged and set overflow <= 1.
REQ-020 SHALL, on pop with !empty (push low): set d_out <= mem[sp-1] and sp <= sp-1.
REQ-021 SHALL, on pop or top with empty (push low): leave d_out and sp unchanged and set underflow <= 1.
REQ-022 SHALL, on top only with !empty: set d_out <= mem[sp-1] and leave sp unchanged.
REQ-023 SHALL, when pop and top are both high: behave as pop (pop dominates).
REQ-024 SHALL, when push and pop are both high with !empty: set d_out <= old mem[sp-1] and mem[sp-1] <= d_in, with sp unchanged (replace top); full does not block this case.
REQ-025 SHALL, when push and pop are both high with empty: behave as push only, set underflow <= 1, and leave d_out unchanged.
REQ-026 SHALL, when push and top are both high (pop low) with !empty: set d_out <= old mem[sp-1] and apply the push per REQ-018/019.
REQ-027 SHALL hold all state when push, pop and top are all low.
REQ-028 SHALL, on clr_err high: clear overflow and underflow on that edge.
- An error event on the same edge wins (flag stays or becomes 1).
REQ-029 SHALL never wrap sp.
- sp stays in the range 0..DEPTH inclusive.
- Out-of-range operations are dropped per REQ-019/021.

Reset
REQ-030 SHALL, on rst high: immediately (asynchronously) set sp=0, d_out=0, overflow=0 and underflow=0, giving empty=1, full=0, count=0.
REQ-031 SHALL not reset the contents of the storage array; they are don't-care after reset.
REQ-032 SHALL abandon any operation in progress when rst is asserted mid-cycle.
- No write or pointer update occurs on an edge where rst is high.
REQ-033 SHALL resume normal operation on the first rising edge after rst deasserts.

Verification
REQ-034 Push 0x11, 0x22, 0x33; then pop x3 -> d_out 0x33, 0x22, 0x11 on successive edges; count 3,2,1,0; empty=1 at end; no flags set.
REQ-035 Push 9 values 0x01..0x09 (DEPTH=8) -> full=1 after the 8th; 9th push dropped with overflow=1; pops return 0x08 down to 0x01.
REQ-036 From reset, pop then top -> d_out stays 0x00, underflow=1, count=0; clr_err -> underflow=0 next edge.
REQ-037 Push 0xAA; then push 0x55 with pop -> d_out=0xAA, count=1; then top -> d_out=0x55.
REQ-038 Push 0x10, 0x20; assert rst asynchronously between edges -> count=0, d_out=0, flags 0 before the next edge; then push 0x77 and top -> d_out=0x77.
REQ-039 Fill to full, then push 0xEE with pop -> top replaced with 0xEE, old top on d_out, no overflow, count stays 8.

Source files
------------

// File: rtl/stack_unit_if.sv
// Stack access bundle: operation strobes and write data in, read data and status out.
// Latency: none in the bundle itself; the stack registers its outputs.
// Backpressure: none; full/empty are advisory and dropped operations set sticky flags.
interface stack_unit_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  // Requester side
  logic             push;
  logic             pop;
  logic             top;
  logic [WIDTH-1:0] d_in;
  logic             clr_err;

  // Stack side
  logic [WIDTH-1:0] d_out;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, top, d_in, clr_err,
    input  d_out, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, top, d_in, clr_err,
    output d_out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack with push/pop/top, replace-top on push+pop, and sticky overflow/underflow flags.
// Latency: one cycle; d_out, count and flags reflect an operation after the sampling edge.
// Backpressure: none; pushes when full and reads when empty are dropped and flagged.
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic        clk,
  input logic        rst,
  stack_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Storage is never reset; its contents are meaningless until written.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    sp;
  logic [WIDTH-1:0] d_out_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    sp_idx;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic             rd_en;
  logic [CW-1:0]    sp_nxt;
  logic             ovf_set;
  logic             unf_set;

  assign is_empty = (sp == '0);
  assign is_full  = (sp == CW'(DEPTH));

  // With a power-of-two depth, truncating sp-1 to AW bits also gives DEPTH-1 when full.
  assign top_idx = AW'(sp - CW'(1));
  // Only used for writes when not full, so the truncated value is always in range.
  assign sp_idx  = sp[AW-1:0];

  // Decode the operation strobes into write, read, pointer and flag actions.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp_idx;
    rd_en   = 1'b0;
    sp_nxt  = sp;
    ovf_set = 1'b0;
    unf_set = 1'b0;

    if (bus.push && bus.pop) begin
      // Pop dominates top, so push+pop+top is handled here as well.
      if (!is_empty) begin
        // Replace top: old top goes out, new value takes its slot, depth unchanged.
        wr_en  = 1'b1;
        wr_idx = top_idx;
        rd_en  = 1'b1;
      end else begin
        // Nothing to pop: degrade to a plain push and record the bad pop.
        wr_en   = 1'b1;
        wr_idx  = sp_idx;
        sp_nxt  = sp + CW'(1);
        unf_set = 1'b1;
      end
    end else if (bus.push) begin
      if (bus.top) begin
        // Peek reads the pre-push top; peeking an empty stack is an underflow.
        if (!is_empty) begin
          rd_en = 1'b1;
        end else begin
          unf_set = 1'b1;
        end
      end
      if (!is_full) begin
        wr_en  = 1'b1;
        wr_idx = sp_idx;
        sp_nxt = sp + CW'(1);
      end else begin
        ovf_set = 1'b1;
      end
    end else if (bus.pop) begin
      if (!is_empty) begin
        rd_en  = 1'b1;
        sp_nxt = sp - CW'(1);
      end else begin
        unf_set = 1'b1;
      end
    end else if (bus.top) begin
      if (!is_empty) begin
        rd_en = 1'b1;
      end else begin
        unf_set = 1'b1;
      end
    end
  end

  // Write the storage array; a reset-high edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_idx] <= bus.d_in;
    end
  end

  // Pointer, read register and sticky flags; error events win over a same-edge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp          <= '0;
      d_out_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      sp <= sp_nxt;
      if (rd_en) begin
        d_out_q <= mem[top_idx];
      end
      overflow_q  <= ovf_set | (overflow_q  & ~bus.clr_err);
      underflow_q <= unf_set | (underflow_q & ~bus.clr_err);
    end
  end

  assign bus.d_out     = d_out_q;
  assign bus.count     = sp;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: reset, LIFO order, full/empty edges, replace-top, async reset.
// Latency: expects results one edge after each operation is applied.
// Backpressure: none; dropped operations are checked through the sticky flags.
module tb_stack_unit;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  stack_unit_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one operation for a single edge, then sample 1 time unit after that edge.
  task automatic op(input logic p_push, input logic p_pop, input logic p_top,
                    input logic [WIDTH-1:0] p_din, input logic p_clr);
    bus.push    = p_push;
    bus.pop     = p_pop;
    bus.top     = p_top;
    bus.d_in    = p_din;
    bus.clr_err = p_clr;
    @(posedge clk);
    #1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.top     = 1'b0;
    bus.d_in    = '0;
    bus.clr_err = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_dout, input logic [31:0] e_cnt,
                           input logic [31:0] e_ovf, input logic [31:0] e_unf);
    chk({tag, ".d_out"},     32'(bus.d_out),     e_dout);
    chk({tag, ".count"},     32'(bus.count),     e_cnt);
    chk({tag, ".empty"},     32'(bus.empty),     (e_cnt == 0) ? 32'd1 : 32'd0);
    chk({tag, ".full"},      32'(bus.full),      (e_cnt == DEPTH) ? 32'd1 : 32'd0);
    chk({tag, ".overflow"},  32'(bus.overflow),  e_ovf);
    chk({tag, ".underflow"}, 32'(bus.underflow), e_unf);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.top     = 1'b0;
    bus.d_in    = '0;
    bus.clr_err = 1'b0;

    // Reset state
    @(posedge clk);
    #1;
    chk_state("reset", 'h00, 0, 0, 0);
    rst = 1'b0;

    // Pop and top on empty: d_out holds, underflow sticks, clear drops it
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_state("pop_empty", 'h00, 0, 0, 1);
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("top_empty", 'h00, 0, 0, 1);
    op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk_state("clr_unf", 'h00, 0, 0, 0);
    // Error on the same edge as a clear keeps the flag set
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk("clr_vs_err.underflow", 32'(bus.underflow), 1);
    op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_again.underflow", 32'(bus.underflow), 0);

    // LIFO order
    op(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
    chk("push11.count", 32'(bus.count), 1);
    op(1'b1, 1'b0, 1'b0, 8'h22, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
    chk_state("push33", 'h00, 3, 0, 0);
    op(1'b0, 1'b0, 1'b0, 8'h99, 1'b0);
    chk_state("idle_hold", 'h00, 3, 0, 0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_state("pop1", 'h33, 2, 0, 0);
    op(1'b0, 1'b1, 1'b1, 8'h00, 1'b0);
    chk_state("pop_top", 'h22, 1, 0, 0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_state("pop3", 'h11, 0, 0, 0);

    // Replace top with push+pop, then peek the replacement
    op(1'b1, 1'b0, 1'b0, 8'hAA, 1'b0);
    op(1'b1, 1'b1, 1'b0, 8'h55, 1'b0);
    chk_state("replace", 'hAA, 1, 0, 0);
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("top_after_replace", 'h55, 1, 0, 0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_state("drain_55", 'h55, 0, 0, 0);

    // Push+pop on empty behaves as push with underflow
    op(1'b1, 1'b1, 1'b0, 8'h3C, 1'b0);
    chk_state("pushpop_empty", 'h55, 1, 0, 1);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    chk_state("pushpop_empty_pop", 'h3C, 0, 0, 0);

    // Fill past full: 9th push dropped, overflow set
    for (int i = 1; i <= DEPTH; i++) begin
      op(1'b1, 1'b0, 1'b0, WIDTH'(i), 1'b0);
    end
    chk_state("fill", 'h3C, DEPTH, 0, 0);
    op(1'b1, 1'b0, 1'b0, 8'h09, 1'b0);
    chk_state("push_full", 'h3C, DEPTH, 1, 0);
    // Push+top when full: peeks the top, push still dropped
    op(1'b1, 1'b0, 1'b1, 8'h0A, 1'b0);
    chk_state("pushtop_full", 'h08, DEPTH, 1, 0);
    for (int i = DEPTH; i >= 1; i--) begin
      op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
      chk($sformatf("drain%0d.d_out", i), 32'(bus.d_out), 32'(i));
      chk($sformatf("drain%0d.count", i), 32'(bus.count), 32'(i - 1));
    end
    chk_state("drained", 'h01, 0, 1, 0);
    op(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    chk("clr_ovf.overflow", 32'(bus.overflow), 0);

    // Refill, then replace top while full: no overflow, count stays DEPTH
    for (int i = 1; i <= DEPTH; i++) begin
      op(1'b1, 1'b0, 1'b0, WIDTH'(8'h40 + i), 1'b0);
    end
    op(1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
    chk_state("replace_full", 'h48, DEPTH, 0, 0);
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("top_full", 'hEE, DEPTH, 0, 0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_state("pop_below_top", 'h47, DEPTH - 2, 0, 0);

    // Asynchronous reset between edges clears pointer, d_out and flags at once
    op(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk_state("async_rst_a", 'h00, 0, 0, 0);
    rst = 1'b0;
    op(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    op(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    chk_state("pre_rst", 'h10, 0, 0, 1);
    op(1'b1, 1'b0, 1'b0, 8'h10, 1'b0);
    op(1'b1, 1'b0, 1'b0, 8'h20, 1'b0);
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("pre_rst2", 'h20, 2, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_state("async_rst_b", 'h00, 0, 0, 0);
    // Hold reset across an edge with an operation pending: it must be ignored
    bus.push = 1'b1;
    bus.d_in = 8'h99;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    chk_state("rst_blocks_push", 'h00, 0, 0, 0);
    rst = 1'b0;
    op(1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
    op(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    chk_state("post_rst", 'h77, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
